// File: rtl/rgb_pwm_if.sv
// rtl/rgb_pwm_if.sv - signal bundle between the comparator-side driver and the RGB PWM stage
//
// Purpose: groups the control/flag inputs and LED/status outputs of
// rgb_pwm_driver so they travel as one port.
// Signals:
//   en        1 = drive LED, 0 = LED dark
//   r_in/g_in/b_in  comparator flags, asynchronous to clk
//   duty      brightness, LED on for duty of every 2**CNT_W cycles
//   led_r/g/b registered PWM outputs
//   pwm_wrap  last cycle of a PWM period while active
//   changed   1-cycle pulse after a new pattern is latched
// Modports: master drives the inputs, slave is the PWM driver.
interface rgb_pwm_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             r_in;
  logic             g_in;
  logic             b_in;
  logic [CNT_W-1:0] duty;
  logic             led_r;
  logic             led_g;
  logic             led_b;
  logic             pwm_wrap;
  logic             changed;

  modport master (
    output en, r_in, g_in, b_in, duty,
    input  led_r, led_g, led_b, pwm_wrap, changed
  );

  modport slave (
    input  en, r_in, g_in, b_in, duty,
    output led_r, led_g, led_b, pwm_wrap, changed
  );
endinterface

// File: rtl/rgb_pwm_driver.sv
// rtl/rgb_pwm_driver.sv - RGB LED PWM driver with period-aligned pattern update and change flash
//
// Purpose: synchronises the comparator R/G/B flags, latches a new colour
// only at PWM period boundaries and drives the LED with duty-controlled PWM.
// A colour change is shown at full brightness for FLASH_PERIODS periods.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous, active-high reset
//   bus  rgb_pwm_if.slave (en, flags, duty in; led_*, pwm_wrap, changed out)
module rgb_pwm_driver #(
  parameter int CNT_W         = 8,
  parameter int FLASH_PERIODS = 4
) (
  input logic      clk,
  input logic      rst,
  rgb_pwm_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLASH = 2'd2;

  localparam int FW = (FLASH_PERIODS > 0) ? $clog2(FLASH_PERIODS + 1) : 1;
  localparam logic [FW-1:0]    FLASH_LOAD = FW'(FLASH_PERIODS);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] duty_q;
  logic [2:0]       sync1;
  logic [2:0]       rgb_s;
  logic [2:0]       pat;
  logic [2:0]       led;
  logic [FW-1:0]    flash_cnt;
  logic             changed_q;
  logic             at_wrap;

  assign at_wrap = (state != ST_IDLE) && (cnt == CNT_MAX);

  assign bus.led_r    = led[2];
  assign bus.led_g    = led[1];
  assign bus.led_b    = led[0];
  assign bus.pwm_wrap = at_wrap;
  assign bus.changed  = changed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      duty_q    <= '0;
      sync1     <= 3'b000;
      rgb_s     <= 3'b000;
      pat       <= 3'b000;
      led       <= 3'b000;
      flash_cnt <= '0;
      changed_q <= 1'b0;
    end else begin
      sync1     <= {bus.r_in, bus.g_in, bus.b_in};
      rgb_s     <= sync1;
      changed_q <= 1'b0;
      case (state)
        ST_RUN, ST_FLASH: begin
          if (!bus.en) begin
            // Disable wins over a coincident boundary: pattern is left alone.
            state     <= ST_IDLE;
            cnt       <= '0;
            led       <= 3'b000;
            flash_cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            // LED follows cnt by one cycle.
            led <= (state == ST_FLASH) ? pat : (pat & {3{cnt < duty_q}});
            if (at_wrap) begin
              duty_q <= bus.duty;
              if (rgb_s != pat) begin
                pat       <= rgb_s;
                changed_q <= 1'b1;
                if (FLASH_PERIODS > 0) begin
                  state     <= ST_FLASH;
                  flash_cnt <= FLASH_LOAD;
                end
              end else if (state == ST_FLASH) begin
                flash_cnt <= flash_cnt - FW'(1);
                if (flash_cnt == FW'(1)) begin
                  state <= ST_RUN;
                end
              end
            end
          end
        end
        default: begin
          // IDLE (and any illegal encoding): counter parked, LED dark.
          cnt <= '0;
          led <= 3'b000;
          if (bus.en) begin
            state  <= ST_RUN;
            pat    <= rgb_s;
            duty_q <= bus.duty;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb/tb_rgb_pwm_driver.sv - scoreboard bench for rgb_pwm_driver with a period-level reference model
module tb_rgb_pwm_driver;
  localparam int CW  = 4;
  localparam int FP  = 2;
  localparam int PER = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rgb_pwm_if #(.CNT_W(CW)) bus ();

  rgb_pwm_driver #(.CNT_W(CW), .FLASH_PERIODS(FP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  logic [4:0] exp_q[$];

  // stimulus values applied on the next tick
  logic          rst_v;
  logic          en_v;
  logic [2:0]    rgb_v;
  logic [CW-1:0] duty_v;

  // reference model: active flag, position inside period, shown pattern,
  // duty for the running period, remaining full-on periods, flag history
  bit       m_active;
  int       m_pos;
  int       m_dq;
  int       m_flash_left;
  logic [2:0] m_pat;
  logic [2:0] m_led;
  logic [2:0] m_hist1;
  logic [2:0] m_hist2;
  bit       m_chg;
  int       exp_changes = 0;
  int       seen_changes = 0;

  task automatic model_edge();
    logic [2:0] seen_rgb;
    seen_rgb = m_hist2;  // flags as sampled two edges ago
    if (rst_v) begin
      m_active = 0; m_pos = 0; m_dq = 0; m_flash_left = 0;
      m_pat = 3'b000; m_led = 3'b000; m_chg = 0;
      m_hist1 = 3'b000; m_hist2 = 3'b000;
    end else begin
      m_chg = 0;
      if (!m_active) begin
        m_led = 3'b000;
        if (en_v) begin
          m_active = 1; m_pos = 0; m_pat = seen_rgb; m_dq = int'(duty_v);
        end
      end else if (!en_v) begin
        m_active = 0; m_pos = 0; m_led = 3'b000; m_flash_left = 0;
      end else begin
        if (m_flash_left > 0) m_led = m_pat;
        else m_led = (m_pos < m_dq) ? m_pat : 3'b000;
        if (m_pos == PER - 1) begin
          m_dq = int'(duty_v);
          if (seen_rgb != m_pat) begin
            m_pat = seen_rgb; m_chg = 1; m_flash_left = FP; exp_changes++;
          end else if (m_flash_left > 0) begin
            m_flash_left--;
          end
        end
        m_pos = (m_pos + 1) % PER;
      end
      m_hist2 = m_hist1;
      m_hist1 = rgb_v;
    end
    exp_q.push_back({m_led, m_chg, (m_active && m_pos == PER - 1)});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      rst        = rst_v;
      bus.en     = en_v;
      bus.r_in   = rgb_v[2];
      bus.g_in   = rgb_v[1];
      bus.b_in   = rgb_v[0];
      bus.duty   = duty_v;
      model_edge();
    end
  endtask

  task automatic wait_pos(input int p);
    int k;
    k = 0;
    while (!(m_active && m_pos == p) && k < 64) begin
      tick(1);
      k++;
    end
    tests++;
    if (k >= 64) begin
      fails++;
      $display("FAIL wait_pos: position %0d not reached, got pos=%0d active=%0d", p, m_pos, m_active);
    end
  endtask

  // monitor: compares each cycle's outputs with the oldest expected entry
  always @(negedge clk) begin
    logic [4:0] e;
    logic [4:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.led_r, bus.led_g, bus.led_b, bus.changed, bus.pwm_wrap};
      if (bus.changed === 1'b1) seen_changes++;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL outputs t=%0t: got led=%b changed=%b wrap=%b, want led=%b changed=%b wrap=%b",
                 $time, a[4:2], a[1], a[0], e[4:2], e[1], e[0]);
      end
    end
  end

  initial begin
    rst_v = 1; en_v = 1; rgb_v = 3'b100; duty_v = 4'd8;
    rst = 1; bus.en = 1; bus.r_in = 1; bus.g_in = 0; bus.b_in = 0; bus.duty = 4'd8;
    m_active = 0; m_pos = 0; m_dq = 0; m_flash_left = 0;
    m_pat = 0; m_led = 0; m_hist1 = 0; m_hist2 = 0; m_chg = 0;

    // reset held with en and a flag active
    tick(3);

    // green at 4/16
    rst_v = 0; rgb_v = 3'b010; duty_v = 4'd4;
    tick(PER * 5);

    // duty change mid-period, then zero duty
    wait_pos(6);
    duty_v = 4'd12;
    tick(PER * 2 + 8);
    duty_v = 4'd0;
    tick(PER * 2);
    duty_v = 4'd15;
    tick(PER * 2);
    duty_v = 4'd12;
    tick(PER);

    // colour change mid-period: flash then PWM
    wait_pos(5);
    rgb_v = 3'b100;
    tick(PER * 5);

    // short glitch inside a period is never shown
    wait_pos(3);
    rgb_v = 3'b110;
    tick(3);
    rgb_v = 3'b100;
    tick(PER * 2);

    // the same glitch straddling a wrap is latched
    wait_pos(14);
    rgb_v = 3'b110;
    tick(3);
    rgb_v = 3'b100;
    tick(PER * 4);

    // disable during flash, re-enable, reset mid-run
    wait_pos(5);
    rgb_v = 3'b001;
    wait_pos(4);
    en_v = 0;
    tick(4);
    en_v = 1;
    tick(PER * 4);
    wait_pos(7);
    rst_v = 1;
    tick(1);
    rst_v = 0;
    tick(PER * 2);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) rgb_v = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0: duty_v = 4'd0;
          1: duty_v = 4'd15;
          default: duty_v = 4'($urandom_range(0, 15));
        endcase
      end
      en_v  = ($urandom_range(0, 99) != 0);
      rst_v = ($urandom_range(0, 999) == 0);
      tick(1);
    end

    rst_v = 0; en_v = 1;
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
    end
    tests++;
    if (seen_changes != exp_changes) begin
      fails++;
      $display("FAIL change_count: got %0d changed pulses, want %0d", seen_changes, exp_changes);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
